// File: rtl/block_dispatcher.sv
// Block dispatcher: splits a launch of thread_count threads into fixed-size blocks and hands
// them to idle cores one per cycle. Optional cycle counter output under DISPATCH_PERF_EN.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    localparam int TC_W             = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                thread_count,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES-1:0]      core_reset,
    output logic [8*NUM_CORES-1:0]    core_block_id,
    output logic [TC_W*NUM_CORES-1:0] core_thread_count,
    output logic                      done
`ifdef DISPATCH_PERF_EN
    ,output logic [15:0]              perf_cycles
`endif
);

    localparam int TPB_LOG = $clog2(THREADS_PER_BLOCK);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t state_q, state_d;

    logic [7:0]           tc_q;
    logic [8:0]           total_q, dispatched_q, retired_q;
    logic [8:0]           total_calc;
    logic [NUM_CORES-1:0] busy_q;
    logic [7:0]           blk_q [NUM_CORES];
    logic [TC_W-1:0]      cnt_q [NUM_CORES];

    logic [NUM_CORES-1:0] retire_mask;
    logic [3:0]           retire_cnt;
    logic [NUM_CORES-1:0] dispatch_oh;
    logic                 dispatch_en;
    logic [15:0]          base, remaining;
    logic [TC_W-1:0]      dispatch_cnt;

    assign total_calc = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> TPB_LOG;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Completion is judged on the registered retire count, so done follows the last retire by one edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)                  state_d = ST_RUN;
            ST_RUN:  if (retired_q == total_q)   state_d = ST_DONE;
            ST_DONE: if (!start)                 state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        retire_mask = busy_q & core_done;
        retire_cnt  = '0;
        dispatch_oh = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (retire_mask[i]) retire_cnt = retire_cnt + 4'd1;
            if (!busy_q[i] && dispatch_oh == '0) dispatch_oh[i] = 1'b1;
        end
        dispatch_en  = (state_q == ST_RUN) && (dispatched_q != total_q) && (dispatch_oh != '0);
        base         = {7'b0, dispatched_q} << TPB_LOG;
        remaining    = {8'b0, tc_q} - base;
        dispatch_cnt = (remaining >= 16'(THREADS_PER_BLOCK)) ? TC_W'(THREADS_PER_BLOCK)
                                                             : remaining[TC_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc_q         <= '0;
            total_q      <= '0;
            dispatched_q <= '0;
            retired_q    <= '0;
            busy_q       <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                blk_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            if (state_q == ST_IDLE && start) begin
                tc_q         <= thread_count;
                total_q      <= total_calc;
                dispatched_q <= '0;
                retired_q    <= '0;
            end
            if (state_q == ST_RUN) begin
                // Busy bits are sampled before this edge's retire, so a freed core waits one edge.
                busy_q    <= (busy_q & ~retire_mask) | (dispatch_en ? dispatch_oh : '0);
                retired_q <= retired_q + 9'(retire_cnt);
                if (dispatch_en) dispatched_q <= dispatched_q + 9'd1;
            end
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (dispatch_en && dispatch_oh[i]) begin
                    blk_q[i] <= dispatched_q[7:0];
                    cnt_q[i] <= dispatch_cnt;
                end
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                        perf_cycles <= '0;
        else if (state_q == ST_IDLE && start)             perf_cycles <= '0;
        else if (state_q == ST_RUN && perf_cycles != '1)  perf_cycles <= perf_cycles + 16'd1;
    end
`endif

    always_comb begin
        core_start = busy_q;
        core_reset = (state_q == ST_RUN) ? ~busy_q : '1;
        done       = (state_q == ST_DONE);
        core_block_id     = '0;
        core_thread_count = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            core_block_id[8*i +: 8]        = blk_q[i];
            core_thread_count[TC_W*i +: TC_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed self-checking bench for block_dispatcher (NUM_CORES=2, THREADS_PER_BLOCK=4).
module tb_block_dispatcher;

    localparam int NC   = 2;
    localparam int TPB  = 4;
    localparam int TC_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        thread_count;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_start;
    logic [NC-1:0]     core_reset;
    logic [8*NC-1:0]   core_block_id;
    logic [TC_W*NC-1:0] core_thread_count;
    logic              done;
`ifdef DISPATCH_PERF_EN
    logic [15:0]       perf_cycles;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
`ifdef DISPATCH_PERF_EN
        ,.perf_cycles      (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] blk(input int i);
        return core_block_id[8*i +: 8];
    endfunction

    function automatic logic [TC_W-1:0] cnt(input int i);
        return core_thread_count[TC_W*i +: TC_W];
    endfunction

    int          seen [64];
    int          tb_retired;
    int          bad_cnt;
    int          last_cnt;
    int          unique_ids;
    int          out_of_range;
    logic [NC-1:0] prev_start;
    logic        done_seen;

    initial begin
        reset = 1'b1; start = 1'b0; thread_count = '0; core_done = '0;
        #12 reset = 1'b0;
        #1;
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_core_reset", 32'(core_reset), 32'h3);
        check("rst_block_id",   32'(core_block_id), 32'h0);
        check("rst_thread_cnt", 32'(core_thread_count), 32'h0);
        check("rst_done",       32'(done), 32'h0);

        // Test 1: tc=8, two full blocks, start held high through DONE
        thread_count = 8'd8; start = 1'b1;
        step();
        check("t1_launch_no_start", 32'(core_start), 32'h0);
        step();
        check("t1_n1_start",  32'(core_start), 32'h1);
        check("t1_n1_reset",  32'(core_reset), 32'h2);
        check("t1_n1_blk0",   32'(blk(0)), 32'd0);
        check("t1_n1_cnt0",   32'(cnt(0)), 32'd4);
        step();
        check("t1_n2_start",  32'(core_start), 32'h3);
        check("t1_n2_blk1",   32'(blk(1)), 32'd1);
        check("t1_n2_cnt1",   32'(cnt(1)), 32'd4);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        check("t1_retire_start", 32'(core_start), 32'h0);
        check("t1_retire_done",  32'(done), 32'h0);
        step();
        check("t1_done",       32'(done), 32'h1);
        check("t1_done_reset", 32'(core_reset), 32'h3);
`ifdef DISPATCH_PERF_EN
        check("t1_perf", 32'(perf_cycles), 32'd4);
`endif
        step();
        check("t1_done_hold", 32'(done), 32'h1);
        start = 1'b0;
        step();
        check("t1_idle", 32'(done), 32'h0);

        // Test 2: tc=10, third block of 2 threads goes to the core that retired first
        thread_count = 8'd10; start = 1'b1;
        step();
        start = 1'b0; thread_count = 8'd0;
        step(); step();
        step();
        check("t2_both_busy", 32'(core_start), 32'h3);
        core_done = 2'b10;
        step();
        core_done = 2'b00;
        check("t2_retire_edge", 32'(core_start), 32'h1);
        step();
        check("t2_redispatch", 32'(core_start), 32'h3);
        check("t2_blk2",       32'(blk(1)), 32'd2);
        check("t2_cnt2",       32'(cnt(1)), 32'd2);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        check("t2_not_yet_done", 32'(done), 32'h0);
        step();
        check("t2_done", 32'(done), 32'h1);
        step();
        check("t2_idle", 32'(done), 32'h0);

        // Test 3: tc=0, done after two edges with no core ever started
        thread_count = 8'd0; start = 1'b1;
        step();
        check("t3_n_start", 32'(core_start), 32'h0);
        check("t3_n_done",  32'(done), 32'h0);
        step();
        check("t3_done",       32'(done), 32'h1);
        check("t3_core_start", 32'(core_start), 32'h0);
        check("t3_core_reset", 32'(core_reset), 32'h3);
        start = 1'b0;
        step();
        check("t3_idle", 32'(done), 32'h0);

        // Test 4: tc=255, cores finish one cycle after every dispatch
        foreach (seen[k]) seen[k] = 0;
        tb_retired = 0; bad_cnt = 0; last_cnt = -1; out_of_range = 0; done_seen = 1'b0;
        thread_count = 8'd255; start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            core_done  = core_start;
            prev_start = core_start;
            step();
            tb_retired += $countones(prev_start);
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    if (blk(i) > 8'd63) out_of_range++;
                    else seen[blk(i)]++;
                    if (blk(i) == 8'd63) last_cnt = int'(cnt(i));
                    else if (cnt(i) != 3'd4) bad_cnt++;
                end
            end
            if (done) begin
                done_seen = 1'b1;
                check("t4_retires_at_done", 32'(tb_retired), 32'd64);
            end
        end
        core_done = 2'b00;
        check("t4_done_within_budget", 32'(done_seen), 32'h1);
        unique_ids = 0;
        foreach (seen[k]) if (seen[k] == 1) unique_ids++;
        check("t4_unique_ids",  32'(unique_ids), 32'd64);
        check("t4_out_of_range", 32'(out_of_range), 32'd0);
        check("t4_full_cnts",   32'(bad_cnt), 32'd0);
        check("t4_blk63_cnt",   32'(last_cnt), 32'd3);
        step();
        check("t4_idle", 32'(done), 32'h0);

        // Test 5: simultaneous retire of both cores, then redispatch core0 before core1
        thread_count = 8'd16; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("t5_both_busy", 32'(core_start), 32'h3);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        check("t5_both_retired_start", 32'(core_start), 32'h0);
        check("t5_both_retired_reset", 32'(core_reset), 32'h3);
        step();
        check("t5_redisp_core0", 32'(core_start), 32'h1);
        check("t5_blk2_core0",   32'(blk(0)), 32'd2);
        step();
        check("t5_redisp_core1", 32'(core_start), 32'h3);
        check("t5_blk3_core1",   32'(blk(1)), 32'd3);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        step();
        check("t5_done", 32'(done), 32'h1);
        step();
        check("t5_idle", 32'(done), 32'h0);

        // Test 6: asynchronous reset mid-run, then a fresh launch
        thread_count = 8'd8; start = 1'b1;
        step(); step(); step();
        check("t6_busy_before_reset", 32'(core_start), 32'h3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_core_start", 32'(core_start), 32'h0);
        check("t6_rst_core_reset", 32'(core_reset), 32'h3);
        check("t6_rst_block_id",   32'(core_block_id), 32'h0);
        check("t6_rst_thread_cnt", 32'(core_thread_count), 32'h0);
        check("t6_rst_done",       32'(done), 32'h0);
        #2 reset = 1'b0;
        thread_count = 8'd4;
        step();
        step();
        check("t6_fresh_start", 32'(core_start), 32'h1);
        check("t6_fresh_blk",   32'(blk(0)), 32'd0);
        check("t6_fresh_cnt",   32'(cnt(0)), 32'd4);
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        step();
        check("t6_done", 32'(done), 32'h1);
        start = 1'b0;
        step();
        check("t6_idle", 32'(done), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
